pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 16, number of stalled memory-wait cycles tolerated before halt (legal range 2..31).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 ex_rd  input  5  destination register of the instruction in EX.
REQ-006 ex_MemRead  input  1  instruction in EX is a load.
REQ-007 ex_br_taken  input  1  branch in EX resolved taken this cycle.
REQ-008 mem_req  input  1  instruction in MEM accesses data memory.
REQ-009 mem_ready  input  1  data memory completes the access this cycle.
REQ-010 PC_write  output  1  PC update enable.
REQ-011 IF_ID_write  output  1  IF/ID register load enable.
REQ-012 IF_ID_flush  output  1  clear IF/ID register.
REQ-013 ID_EX_flush  output  1  clear ID/EX register (drives its Flush input).
REQ-014 pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB registers.
REQ-015 mem_timeout  output  1  level, high while in HALT.
REQ-016 ctrl_state  output  2  current state: RUN=0, MEM_WAIT=1, HALT=2.

Function
REQ-017 Block SHALL implement states RUN, MEM_WAIT, HALT; all control outputs combinational from state and inputs; zero-cycle latency.
REQ-018 load_use SHALL be ex_MemRead AND ex_rd!=0 AND (ex_rd==id_rs1 OR ex_rd==id_rs2).
REQ-019 mem_stall SHALL be mem_req AND NOT mem_ready.
REQ-020 Default outputs in RUN with no event: PC_write=1, IF_ID_write=1, flushes=0, pipe_hold=0.
REQ-021 Priority in RUN SHALL be mem_stall > branch > load_use.
REQ-022 RUN with mem_stall: PC_write=0, IF_ID_write=0, pipe_hold=1, flushes=0; next state MEM_WAIT; wait_cnt cleared to 0; br_pending captured from ex_br_taken.
REQ-023 RUN with branch (ex_br_taken OR br_pending): IF_ID_flush=1, ID_EX_flush=1, PC_write=1; br_pending cleared.
REQ-024 RUN with load_use only: PC_write=0, IF_ID_write=0, ID_EX_flush=1 (one bubble); stays RUN.
REQ-025 MEM_WAIT with mem_ready=0: outputs as REQ-022; wait_cnt increments; when wait_cnt==WAIT_MAX-1 next state HALT.
REQ-026 MEM_WAIT with mem_ready=1: pipe_hold=0; outputs evaluated as RUN per REQ-021..024 with mem_stall ignored; next state RUN.
REQ-027 ex_br_taken seen during MEM_WAIT SHALL set br_pending; flush applied on exit cycle, never lost.
REQ-028 HALT: PC_write=0, IF_ID_write=0, pipe_hold=1, flushes=0, mem_timeout=1; exit only by reset.
REQ-029 wait_cnt SHALL be 5 bits, never wrap; mem_ready on the same cycle as timeout terminal count SHALL take precedence (exit to RUN).

Reset
REQ-030 reset_n low SHALL immediately force state RUN, wait_cnt=0, br_pending=0, regardless of clk.
REQ-031 Outputs under reset SHALL equal RUN idle values: PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_flush=0, pipe_hold=0, mem_timeout=0, ctrl_state=0 (input-dependent RUN decode is permitted).
REQ-032 Reset asserted mid MEM_WAIT or HALT SHALL discard pending branch and wait count.

Configuration
REQ-033 Macro PIPE_HAZARD_CTRL_PERF_EN defined: add outputs stall_cycles[31:0] (cycles with PC_write=0) and flush_events[31:0] (cycles with branch flush), saturating at 0xFFFFFFFF, reset to 0.
REQ-034 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-035 Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5 in RUN -> PC_write=0, IF_ID_write=0, ID_EX_flush=1 for one cycle; ex_rd=0 -> no stall.
REQ-036 Branch plus load-use same cycle -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1.
REQ-037 mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_hold=1 for 3 cycles, ctrl_state=1, return to 0 on ready cycle.
REQ-038 ex_br_taken=1 during MEM_WAIT -> both flushes=1 on mem_ready cycle exactly once.
REQ-039 mem_ready held 0, WAIT_MAX=16 -> ctrl_state=2 and mem_timeout=1 after 16 stalled cycles; reset_n pulse -> RUN, mem_timeout=0 asynchronously.
REQ-040 With PIPE_HAZARD_CTRL_PERF_EN, after REQ-035 and REQ-036 stimuli -> stall_cycles=1, flush_events=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Groups the signals exchanged between the pipeline datapath and the hazard
// controller.
//   master : pipeline side. It drives the hazard-detection inputs and
//            receives the control outputs.
//   slave  : hazard controller side.
// Inputs to the controller:
//   id_rs1, id_rs2 : source registers of the instruction in ID
//   ex_rd          : destination register of the instruction in EX
//   ex_MemRead     : the instruction in EX is a load
//   ex_br_taken    : a branch in EX resolved taken this cycle
//   mem_req        : the instruction in MEM accesses data memory
//   mem_ready      : data memory completes the access this cycle
// Outputs from the controller:
//   PC_write, IF_ID_write       : load enables
//   IF_ID_flush, ID_EX_flush    : pipeline register clears
//   pipe_hold                   : freezes ID/EX, EX/MEM and MEM/WB
//   mem_timeout                 : high while halted
//   ctrl_state                  : RUN=0, MEM_WAIT=1, HALT=2
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pipe_hazard_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] ex_rd;
   logic       ex_MemRead;
   logic       ex_br_taken;
   logic       mem_req;
   logic       mem_ready;
   logic       PC_write;
   logic       IF_ID_write;
   logic       IF_ID_flush;
   logic       ID_EX_flush;
   logic       pipe_hold;
   logic       mem_timeout;
   logic [1:0] ctrl_state;

   modport master (
      output id_rs1, id_rs2, ex_rd, ex_MemRead, ex_br_taken, mem_req, mem_ready,
      input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold,
             mem_timeout, ctrl_state
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_MemRead, ex_br_taken, mem_req, mem_ready,
      output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold,
             mem_timeout, ctrl_state
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// This module is the hazard controller for a 5-stage pipeline. It handles
// three kinds of hazard:
//   - load-use stalls
//   - taken-branch flushes
//   - data-memory wait stalls, with a timeout into a sticky HALT state
// All control outputs are combinational from the current state and the
// inputs, so they take effect in the same cycle.
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   hz       : pipe_hazard_ctrl_if.slave. It carries the hazard inputs and
//              the control outputs.
//   stall_cycles, flush_events : 32-bit saturating performance counters.
//              They exist only when PIPE_HAZARD_CTRL_PERF_EN is defined.
//
// Parameter:
//   WAIT_MAX : number of MEM_WAIT cycles tolerated before HALT. The legal
//              range is 2..31.
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
   parameter int WAIT_MAX = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]         stall_cycles,
   output logic [31:0]         flush_events
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [4:0] WAIT_TERM = 5'(WAIT_MAX - 1);

   state_t     state_reg;
   logic [4:0] wait_cnt_reg;
   logic       br_pending_reg;

   logic load_use;
   logic mem_stall;
   logic branch;
   logic hold_cond;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_flush;
   logic pipe_hold;

   assign load_use  = hz.ex_MemRead && (hz.ex_rd != 5'd0) &&
                      ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
   assign mem_stall = hz.mem_req && !hz.mem_ready;
   // A branch seen while memory was stalled is still pending, so it is
   // honoured together with any new branch.
   assign branch    = hz.ex_br_taken || br_pending_reg;

   // The pipeline freezes in three cases:
   //   - a new stall is detected in RUN
   //   - memory is still not ready in MEM_WAIT
   //   - the controller is in HALT
   // The cycle on which MEM_WAIT sees mem_ready falls through to the RUN
   // priority decode, with mem_stall ignored.
   assign hold_cond = (state_reg == HALT) ||
                      ((state_reg == MEM_WAIT) && !hz.mem_ready) ||
                      ((state_reg == RUN) && mem_stall);

   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_hold   = 1'b0;
      if (hold_cond) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
      end else if (branch) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         // Insert a single bubble behind the load.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   assign hz.PC_write    = pc_write;
   assign hz.IF_ID_write = if_id_write;
   assign hz.IF_ID_flush = if_id_flush;
   assign hz.ID_EX_flush = id_ex_flush;
   assign hz.pipe_hold   = pipe_hold;
   assign hz.mem_timeout = (state_reg == HALT);
   assign hz.ctrl_state  = state_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= RUN;
         wait_cnt_reg   <= 5'd0;
         br_pending_reg <= 1'b0;
      end else begin
         case (state_reg)
            RUN: begin
               if (mem_stall) begin
                  state_reg      <= MEM_WAIT;
                  wait_cnt_reg   <= 5'd0;
                  br_pending_reg <= branch;
               end else begin
                  // Any pending branch is consumed by this cycle's flush.
                  br_pending_reg <= 1'b0;
               end
            end
            MEM_WAIT: begin
               if (hz.mem_ready) begin
                  // mem_ready wins over the terminal count.
                  state_reg      <= RUN;
                  br_pending_reg <= 1'b0;
               end else begin
                  br_pending_reg <= branch;
                  if (wait_cnt_reg == WAIT_TERM) begin
                     state_reg <= HALT;
                  end
                  if (wait_cnt_reg != 5'h1F) begin
                     wait_cnt_reg <= wait_cnt_reg + 5'd1;
                  end
               end
            end
            HALT: begin
               state_reg <= HALT;
            end
            default: begin
               state_reg <= RUN;
            end
         endcase
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= 32'd0;
         flush_events <= 32'd0;
      end else begin
         if (!pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (if_id_flush && (flush_events != 32'hFFFF_FFFF)) begin
            flush_events <= flush_events + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

   // Expected outputs are packed as:
   //   {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold,
   //    mem_timeout, ctrl_state[1:0]}
   localparam logic [7:0] O_IDLE   = 8'b1100_0000;
   localparam logic [7:0] O_BUBBLE = 8'b0001_0000;
   localparam logic [7:0] O_FLUSH  = 8'b1111_0000;
   localparam logic [7:0] O_STALLR = 8'b0000_1000;  // mem stall seen in RUN
   localparam logic [7:0] O_STALLW = 8'b0000_1001;  // stalled in MEM_WAIT
   localparam logic [7:0] O_HALT   = 8'b0000_1110;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
`endif

   pipe_hazard_ctrl #(.WAIT_MAX(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .hz           (hz)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
`endif
   );

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       mq;
      logic       my;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [9];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] outs();
      return {hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_flush,
              hz.pipe_hold, hz.mem_timeout, hz.ctrl_state};
   endfunction

   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = outs();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end else begin
         $display("ok   %s: %b", name, act);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic mq, input logic my);
      hz.id_rs1      = rs1;
      hz.id_rs2      = rs2;
      hz.ex_rd       = rd;
      hz.ex_MemRead  = mr;
      hz.ex_br_taken = br;
      hz.mem_req     = mq;
      hz.mem_ready   = my;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The bench is called at posedge+1. It pulses reset asynchronously and
   // returns at the next posedge+1.
   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      //        rs1    rs2    rd     mr    br    mq    my    expected
      vecs[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
      vecs[1] = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_BUBBLE};
      vecs[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
      vecs[3] = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_BUBBLE};
      vecs[4] = '{5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
      vecs[5] = '{5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
      vecs[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FLUSH};
      vecs[7] = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_FLUSH};
      vecs[8] = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, O_BUBBLE};

      // Reset: the outputs must show RUN idle values while reset is held.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      check("reset_idle", O_IDLE);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Table of single-cycle RUN decodes.
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr,
               vecs[i].br, vecs[i].mq, vecs[i].my);
         #2;
         check($sformatf("vec%0d", i), vecs[i].exp);
         tick();
      end

      // A load-use followed by branch plus load-use, starting from reset.
      do_reset();
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      #2; check("lu_seq", O_BUBBLE); tick();
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      #2; check("br_lu_seq", O_FLUSH); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2; check("after_br_lu", O_IDLE);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      check32("stall_cycles", stall_cycles, 32'd1);
      check32("flush_events", flush_events, 32'd1);
`endif
      tick();

      // Three stalled cycles, then memory becomes ready.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; check("mw_c1", O_STALLR); tick();
      #2; check("mw_c2", O_STALLW); tick();
      #2; check("mw_c3", O_STALLW); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      #2; check("mw_ready", 8'b1100_0001); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2; check("mw_back_run", O_IDLE); tick();

      // A branch taken during MEM_WAIT flushes exactly once, on the exit cycle.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; check("brw_c1", O_STALLR); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #2; check("brw_c2", O_STALLW); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; check("brw_c3", O_STALLW); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      #2; check("brw_exit_flush", 8'b1111_0001); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2; check("brw_no_repeat", O_IDLE); tick();

      // mem_ready arriving at the terminal count exits to RUN, not HALT.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; check("term_c0", O_STALLR); tick();
      for (int k = 0; k < 15; k++) begin
         #2; check($sformatf("term_wait%0d", k), O_STALLW); tick();
      end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      #2; check("term_ready", 8'b1100_0001); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2; check("term_run", O_IDLE); tick();

      // Timeout into HALT. HALT ignores mem_ready, and reset clears it
      // asynchronously.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; check("to_c0", O_STALLR); tick();
      for (int k = 0; k < 16; k++) begin
         #2; check($sformatf("to_wait%0d", k), O_STALLW); tick();
      end
      #2; check("halt", O_HALT);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      #2; check("halt_sticky", O_HALT);
      reset_n = 1'b0;
      #1; check("halt_async_reset", O_IDLE);
      reset_n = 1'b1;
      tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2; check("post_halt_run", O_IDLE); tick();

      // Reset during MEM_WAIT discards a pending branch.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; check("rstw_c1", O_STALLR); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #2; check("rstw_c2", O_STALLW); tick();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1; check("rstw_async", O_IDLE);
      reset_n = 1'b1;
      tick();
      #2; check("rstw_no_stale_flush", O_IDLE); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
